execute_cycle: RTL
==================

// Module: execute_cycle
// PURPOSE
//  Execute stage of the 5-stage RV32I pipeline; consumer of the ID/EX bundle produced by decode.
//  Selects forwarded operands, runs the ALU, resolves BEQ and computes the branch target.
//  Registers the EX/MEM pipeline bundle for the memory stage.
//  PCSrcE/PCTargetE feed fetch combinationally in the same cycle.
// PARAMETERS
//  XLEN  32  datapath width (RD1/RD2/Imm/PC/ALU result)
// PORTS
//  clk          in   1     pipeline clock, all state on rising edge
//  rst          in   1     synchronous reset, active-high
//  RegWriteE    in   1     ID/EX: write register file at WB
//  ALUSrcE      in   1     ID/EX: 1 = SrcB is Imm_Ext_E, 0 = forwarded RD2
//  MemWriteE    in   1     ID/EX: store
//  ResultSrcE   in   1     ID/EX: 1 = WB from memory, 0 = from ALU
//  BranchE      in   1     ID/EX: BEQ instruction
//  ALUControlE  in   3     ID/EX: ALU op (encoding below)
//  RD1_E        in   XLEN  ID/EX: rs1 register value
//  RD2_E        in   XLEN  ID/EX: rs2 register value
//  Imm_Ext_E    in   XLEN  ID/EX: sign-extended immediate
//  RD_E         in   5     ID/EX: destination register
//  PCE          in   XLEN  ID/EX: instruction PC
//  PCPlus4E     in   XLEN  ID/EX: PC+4
//  ForwardAE    in   2     rs1 select: 00 RD1_E, 01 ResultW, 10 ALUResultM, 11 RD1_E
//  ForwardBE    in   2     rs2 select, same encoding against RD2_E
//  ResultW      in   XLEN  writeback result for forwarding
//  PCSrcE       out  1     BranchE & ZeroE (combinational)
//  PCTargetE    out  XLEN  PCE + Imm_Ext_E (combinational, mod 2^XLEN)
//  RegWriteM    out  1     EX/MEM registered
//  MemWriteM    out  1     EX/MEM registered
//  ResultSrcM   out  1     EX/MEM registered
//  RD_M         out  5     EX/MEM registered
//  ALUResultM   out  XLEN  EX/MEM registered ALU result
//  WriteDataM   out  XLEN  EX/MEM registered forwarded rs2 (pre-ALUSrc mux)
//  PCPlus4M     out  XLEN  EX/MEM registered
// BEHAVIOUR
//  - SrcAE = mux(ForwardAE); WriteDataE = mux(ForwardBE); SrcBE = ALUSrcE ? Imm_Ext_E : WriteDataE.
//  - ALUResultM used for forwarding is this block's own registered output (previous instr).
//  - ALU: 000 add, 001 sub, 010 and, 011 or, 101 slt (signed: 1 if SrcA<SrcB, else 0);
//    100/110/111 -> result 0. Add/sub wrap mod 2^XLEN, no overflow flag exported.
//  - slt: sign of (SrcA-SrcB) XOR signed overflow; zero-extended to XLEN.
//  - ZeroE = (ALUResultE == 0); decode issues BEQ with ALUControl 001.
//  - PCSrcE/PCTargetE are purely combinational off ID/EX inputs; zero latency.
//  - EX/MEM register: latency 1; every rising edge captures RegWriteE, MemWriteE,
//    ResultSrcE, RD_E, ALUResultE, WriteDataE, PCPlus4E. No enable, no stall.
//  - Reset (sync): all registered outputs -> 0 on the edge where rst=1; rst has
//    priority over capture. Reset mid-instruction discards the in-flight EX bundle.
//  - After reset, ForwardXE=10 forwards 0 (ALUResultM reset value).
//  - Forward select 11 treated as 00; never driven by hazard unit.
//  - Branch instructions still propagate RegWriteE/MemWriteE as given (decode drives 0).
// TESTING
//  1. rst=1 one cycle -> all *M outputs 0; PCSrcE=0 with BranchE=0.
//  2. ALUControl=000, ALUSrcE=1, RD1=0x10, Imm=0xFFFFFFFC, Fwd=00 -> next edge ALUResultM=0x0C.
//  3. Back-to-back: instr1 result 0x5 -> ALUResultM; instr2 ForwardAE=10, op add, SrcB=3 -> 0x8.
//  4. ForwardBE=01, ResultW=0xDEAD, MemWriteE=1, ALUSrcE=1 -> WriteDataM=0xDEAD, MemWriteM=1.
//  5. BEQ: RD1=RD2=7, op 001, BranchE=1, PCE=0x100, Imm=0x20 -> PCSrcE=1, PCTargetE=0x120 same cycle;
//     RD2=8 -> PCSrcE=0.
//  6. slt: SrcA=0x80000000, SrcB=1 -> 1; SrcA=0x7FFFFFFF, SrcB=0xFFFFFFFF -> 0;
//     rst asserted with valid bundle -> outputs 0 next edge.

Source files
------------

// File: rtl/execute_if.sv
// ID/EX -> EX/MEM bundle of the execute stage, plus the forwarding inputs and
// the combinational branch outputs that go back to fetch.
interface execute_if #(
  parameter int XLEN = 32
);
  // ID/EX bundle from decode
  logic            RegWriteE;
  logic            ALUSrcE;
  logic            MemWriteE;
  logic            ResultSrcE;
  logic            BranchE;
  logic [2:0]      ALUControlE;
  logic [XLEN-1:0] RD1_E;
  logic [XLEN-1:0] RD2_E;
  logic [XLEN-1:0] Imm_Ext_E;
  logic [4:0]      RD_E;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;

  // Hazard unit selects and writeback value used for forwarding
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;

  // Same-cycle branch resolution towards fetch
  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;

  // EX/MEM bundle towards the memory stage
  logic            RegWriteM;
  logic            MemWriteM;
  logic            ResultSrcM;
  logic [4:0]      RD_M;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW,
    input  PCSrcE, PCTargetE,
           RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, ALUControlE,
           RD1_E, RD2_E, Imm_Ext_E, RD_E, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW,
    output PCSrcE, PCTargetE,
           RegWriteM, MemWriteM, ResultSrcM, RD_M, ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline: operand forwarding, ALU, BEQ
// resolution, branch target, and the EX/MEM pipeline register.
module execute_cycle #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rst,
  execute_if.slave ex
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RESULT_W = 2'b01;
  localparam logic [1:0] FWD_ALU_M    = 2'b10;

  typedef struct packed {
    logic            reg_write;
    logic            mem_write;
    logic            result_src;
    logic [4:0]      rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] write_data;
    logic [XLEN-1:0] pc_plus4;
  } ex_mem_t;

  ex_mem_t ex_mem_d;
  ex_mem_t ex_mem_q;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] b_operand;
  logic [XLEN-1:0] sum;
  logic            is_sub;
  logic            overflow;
  logic            less_than;
  logic [XLEN-1:0] alu_result;
  logic            zero;

  // Forwarding from EX/MEM uses this stage's own registered result, i.e. the
  // previous instruction; select 11 is never issued and falls back to the register.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    src_a = ex.RD1_E;
    unique case (ex.ForwardAE)
      FWD_RESULT_W: src_a = ex.ResultW;
      FWD_ALU_M:    src_a = ex_mem_q.alu_result;
      default:      src_a = ex.RD1_E;
    endcase
  end

  always_comb begin
    write_data = ex.RD2_E;
    unique case (ex.ForwardBE)
      FWD_RESULT_W: write_data = ex.ResultW;
      FWD_ALU_M:    write_data = ex_mem_q.alu_result;
      default:      write_data = ex.RD2_E;
    endcase
  end

  assign src_b = ex.ALUSrcE ? ex.Imm_Ext_E : write_data;

  // One adder serves add, sub and slt; subtraction is A + ~B + 1.
  assign is_sub    = (ex.ALUControlE == ALU_SUB) || (ex.ALUControlE == ALU_SLT);
  assign b_operand = is_sub ? ~src_b : src_b;
  assign sum       = src_a + b_operand + {{(XLEN-1){1'b0}}, is_sub};

  // Signed overflow of A-B: operands differ in sign and the result sign differs from A.
  assign overflow  = (src_a[XLEN-1] ^ src_b[XLEN-1]) & (sum[XLEN-1] ^ src_a[XLEN-1]);
  assign less_than = sum[XLEN-1] ^ overflow;

  always_comb begin
    alu_result = '0;
    unique case (ex.ALUControlE)
      ALU_ADD: alu_result = sum;
      ALU_SUB: alu_result = sum;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_SLT: alu_result = {{(XLEN-1){1'b0}}, less_than};
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Branch decision and target go straight to fetch in this cycle.
  assign ex.PCSrcE    = ex.BranchE & zero;
  assign ex.PCTargetE = ex.PCE + ex.Imm_Ext_E;

  always_comb begin
    ex_mem_d            = '0;
    ex_mem_d.reg_write  = ex.RegWriteE;
    ex_mem_d.mem_write  = ex.MemWriteE;
    ex_mem_d.result_src = ex.ResultSrcE;
    ex_mem_d.rd         = ex.RD_E;
    ex_mem_d.alu_result = alu_result;
    ex_mem_d.write_data = write_data;
    ex_mem_d.pc_plus4   = ex.PCPlus4E;
  end

  // EX/MEM captures unconditionally every edge; there is no stall or enable.
  always_ff @(posedge clk) begin
    // NOTE: reset clears the whole bundle and wins over capture, so an
    // instruction in flight when rst rises is dropped rather than retired.
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      ex_mem_q <= '0;
    end else begin
      ex_mem_q <= ex_mem_d;
    end
  end

  assign ex.RegWriteM  = ex_mem_q.reg_write;
  assign ex.MemWriteM  = ex_mem_q.mem_write;
  assign ex.ResultSrcM = ex_mem_q.result_src;
  assign ex.RD_M       = ex_mem_q.rd;
  assign ex.ALUResultM = ex_mem_q.alu_result;
  assign ex.WriteDataM = ex_mem_q.write_data;
  assign ex.PCPlus4M   = ex_mem_q.pc_plus4;

endmodule
